// File: rtl/uart_msg_sender_if.sv
// uart_msg_sender_if: request/status bundle between a controller and the UART message sender
interface uart_msg_sender_if;
  logic       trig;
  logic [1:0] mode;
  logic       stop;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic [7:0] char_cnt;
  modport master (output trig, mode, stop, input tx, busy, tx_done, char_cnt);
  modport slave (input trig, mode, stop, output tx, busy, tx_done, char_cnt);
endinterface

// File: rtl/uart_msg_sender.sv
// uart_msg_sender: UART transmitter sending an incrementing character sequence; UART_PARITY_EN adds an even parity bit
module uart_msg_sender #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         BAUD       = 9600,
  parameter int         DATA_BITS  = 8,
  parameter int         STOP_BITS  = 1,
  parameter int         MSG_LEN    = 16,
  parameter logic [7:0] CHAR_FIRST = 8'h30,
  parameter logic [7:0] CHAR_LAST  = 8'h7A
) (
  input logic clk,
  input logic reset,
  uart_msg_sender_if.slave bus
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
`ifdef UART_PARITY_EN
  localparam logic [7:0] MASK = 8'((1 << DATA_BITS) - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic sidx;
  logic [7:0] cur_char;
  logic [7:0] sh;
  logic [1:0] mode_r;
  logic last;
  logic cont;
  logic [7:0] cnt_next;
  assign last = cnt == '0;
  assign cnt_next = bus.char_cnt == 8'hFF ? 8'hFF : bus.char_cnt + 8'd1;
  // decide at the end of a frame whether another character follows immediately
  always_comb cont = mode_r == 2'b10 ? !bus.stop : mode_r == 2'b01 ? (int'(cnt_next) < MSG_LEN) && !bus.stop : 1'b0;
  // frame sequencer: every state holds its bit for DIV cycles, outputs are registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sidx <= 1'b0;
      cur_char <= CHAR_FIRST;
      sh <= '0;
      mode_r <= 2'b00;
      bus.tx <= 1'b1;
      bus.busy <= 1'b0;
      bus.tx_done <= 1'b0;
      bus.char_cnt <= '0;
    end else begin
      bus.tx_done <= 1'b0;
      case (state)
        IDLE: if (bus.trig) begin
          state <= START;
          cnt <= RELOAD;
          mode_r <= bus.mode == 2'b11 ? 2'b00 : bus.mode;
          bus.tx <= 1'b0;
          bus.busy <= 1'b1;
          bus.char_cnt <= '0;
        end
        START: if (last) begin
          state <= DATA;
          cnt <= RELOAD;
          idx <= '0;
          bus.tx <= cur_char[0];
          sh <= cur_char >> 1;
        end else cnt <= cnt - ONE;
        DATA: if (last) begin
          cnt <= RELOAD;
          if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state <= PARITY;
            bus.tx <= ^(cur_char & MASK);
`else
            state <= STOP;
            sidx <= 1'(STOP_BITS - 1);
            bus.tx <= 1'b1;
`endif
          end else begin
            idx <= idx + 3'd1;
            bus.tx <= sh[0];
            sh <= sh >> 1;
          end
        end else cnt <= cnt - ONE;
`ifdef UART_PARITY_EN
        PARITY: if (last) begin
          state <= STOP;
          cnt <= RELOAD;
          sidx <= 1'(STOP_BITS - 1);
          bus.tx <= 1'b1;
        end else cnt <= cnt - ONE;
`endif
        STOP: begin
          if (cnt == ONE && !sidx) bus.tx_done <= 1'b1;
          if (!last) cnt <= cnt - ONE;
          else if (sidx) begin
            sidx <= 1'b0;
            cnt <= RELOAD;
          end else begin
            bus.char_cnt <= cnt_next;
            cur_char <= cur_char == CHAR_LAST ? CHAR_FIRST : cur_char + 8'd1;
            cnt <= cont ? RELOAD : '0;
            state <= cont ? START : IDLE;
            bus.tx <= !cont;
            bus.busy <= cont;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_msg_sender.md
UART_MSG_SENDER -- requirements
Module: uart_msg_sender

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate; DIV = CLK_HZ/BAUD (integer, truncated), clock cycles per bit; DIV >= 2.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, range 5..8.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame, 1 or 2.
REQ-005 Parameter MSG_LEN, default 16, characters per burst, range 1..255.
REQ-006 Parameter CHAR_FIRST, default 8'h30, first character of sequence.
REQ-007 Parameter CHAR_LAST, default 8'h7A, last character before wrap; CHAR_LAST >= CHAR_FIRST.
REQ-008 clk  input  1  system clock; all state on rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 trig  input  1  start request, one-cycle pulse, debounced upstream.
REQ-011 mode  input  2  00 single char, 01 burst of MSG_LEN, 10 continuous, 11 treated as 00; sampled only on accepted trig.
REQ-012 stop  input  1  level; ends burst/continuous after current character.
REQ-013 tx  output  1  serial line, idle high.
REQ-014 busy  output  1  high from accepted trig until final stop bit ends.
REQ-015 tx_done  output  1  one-cycle pulse at end of each character's last stop bit.
REQ-016 char_cnt  output  8  characters sent in current request, saturating at 255.

Function
REQ-017 FSM states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-018 IDLE: trig=1 accepted -> START next cycle; tx low in cycle after trig (latency 1); busy high same cycle as tx low; char_cnt cleared to 0.
REQ-019 trig while busy=1 ignored, no queuing.
REQ-020 Bit counter reloads at each state entry; every bit held exactly DIV cycles.
REQ-021 START: tx=0 for one bit -> DATA; DATA: DATA_BITS bits of cur_char, LSB first -> PARITY (if compiled) else STOP; STOP: tx=1 for STOP_BITS bit periods.
REQ-022 Last stop-bit cycle: tx_done=1, char_cnt increments, cur_char advances; cur_char==CHAR_LAST wraps to CHAR_FIRST.
REQ-023 After STOP: mode 00 -> IDLE; mode 01 -> START if char_cnt (post-increment) < MSG_LEN and stop=0, else IDLE; mode 10 -> START if stop=0, else IDLE.
REQ-024 Back-to-back characters have zero idle gap: next start bit begins the cycle after last stop-bit cycle.
REQ-025 stop sampled only in last stop-bit cycle; stop never truncates a frame.
REQ-026 cur_char persists across requests (not reset by trig); only reset restores CHAR_FIRST.
REQ-027 DATA_BITS < 8: only low DATA_BITS of cur_char transmitted.
REQ-028 busy falls in the cycle FSM returns to IDLE; trig in that same cycle is accepted.

Reset
REQ-029 reset low asynchronously forces IDLE, tx=1, busy=0, tx_done=0, char_cnt=0, cur_char=CHAR_FIRST, counters 0.
REQ-030 reset mid-frame aborts frame immediately; line returns high, no tx_done issued.
REQ-031 Release of reset is synchronous to clk; first trig honoured on first cycle after release.

Configuration
REQ-032 Macro UART_PARITY_EN defined: PARITY state inserted after DATA, one bit period, even parity (XOR of transmitted data bits).
REQ-033 Macro UART_PARITY_EN undefined: no PARITY state, no parity logic; frame = 1 + DATA_BITS + STOP_BITS bits.

Verification (CLK_HZ=1_000_000, BAUD=100_000, DIV=10, defaults otherwise)
REQ-034 Reset, mode=00, trig once -> tx low 1 cycle after trig, frame 0,0,0,0,1,1,0,0 (8'h30 LSB first), stop high; 100 cycles total; tx_done once; busy 100 cycles.
REQ-035 Mode=01, MSG_LEN=3, trig -> '0','1','2' back-to-back, 300 busy cycles, 3 tx_done pulses, char_cnt=3.
REQ-036 Mode=10, trig, assert stop during 2nd character -> exactly 2 characters, then IDLE, tx high.
REQ-037 CHAR_FIRST=8'h41, CHAR_LAST=8'h42, three mode-00 triggers -> 'A','B','A'; trig pulse during busy ignored.
REQ-038 Reset low at cycle 45 of a frame -> tx=1 and busy=0 immediately, no tx_done; next trig sends CHAR_FIRST.
REQ-039 UART_PARITY_EN defined, send 8'h31 -> parity bit 1, frame 110 cycles; undefined -> 100 cycles.
